// File: rtl/ring_req_upload.sv
// Request upload stage: buffers whole multi-flit messages in a small
// circular queue and serialises them one flit per grant into the ring FIFO.
module ring_req_upload #(
  parameter int FLIT_W    = 16,
  parameter int MAX_FLITS = 11,
  parameter int DEPTH     = 2,
  parameter int LEN_W     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FLIT_W*MAX_FLITS-1:0] msg_flits,
  input  logic                        v_msg_flits,
  input  logic [LEN_W-1:0]            msg_len,
  input  logic                        req_fifo_rdy,
  output logic [FLIT_W-1:0]           flit_out,
  output logic                        v_flit_out,
  output logic                        flit_tail,
  output logic                        upload_full,
  output logic                        upload_busy,
  output logic                        err_len
);

  localparam int MSG_W = FLIT_W * MAX_FLITS;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [LEN_W:0]   LEN_MAX  = (LEN_W + 1)'(MAX_FLITS);

  logic [MSG_W-1:0]  data_q [DEPTH];
  logic [LEN_W-1:0]  len_q  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [FLIT_W-1:0] flit_q, flit_d;
  logic              vld_q, vld_d;
  logic              tail_q, tail_d;
  logic              err_q, err_d;

  logic              full, busy, len_ok;
  logic              load, send, last;
  logic [MSG_W-1:0]  head;
  logic [LEN_W-1:0]  head_len;
  logic [FLIT_W-1:0] flits [MAX_FLITS];

  always_comb begin
    head     = data_q[rd_ptr_q];
    head_len = len_q[rd_ptr_q];
    for (int i = 0; i < MAX_FLITS; i++) begin
      flits[i] = head[MSG_W-1-FLIT_W*i -: FLIT_W];
    end
  end

  always_comb begin
    full   = (cnt_q == CNT_FULL);
    busy   = (cnt_q != '0);
    len_ok = (msg_len != '0) && ({1'b0, msg_len} <= LEN_MAX);
    // a full queue ignores the source silently; it must hold the message
    load   = v_msg_flits && !full && len_ok;
    send   = req_fifo_rdy && busy;
    last   = (idx_q == head_len - 1'b1);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    idx_d    = idx_q;
    flit_d   = flit_q;
    vld_d    = 1'b0;
    tail_d   = 1'b0;
    err_d    = v_msg_flits && !full && !len_ok;

    if (load) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end

    if (send) begin
      flit_d = flits[idx_q];
      vld_d  = 1'b1;
      tail_d = last;
      if (last) begin
        idx_d    = '0;
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    cnt_d = cnt_q + CNT_W'(load) - CNT_W'(send && last);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      flit_q   <= '0;
      vld_q    <= 1'b0;
      tail_q   <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        len_q[i]  <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      flit_q   <= flit_d;
      vld_q    <= vld_d;
      tail_q   <= tail_d;
      err_q    <= err_d;
      if (load) begin
        data_q[wr_ptr_q] <= msg_flits;
        len_q[wr_ptr_q]  <= msg_len;
      end
    end
  end

  assign flit_out    = flit_q;
  assign v_flit_out  = vld_q;
  assign flit_tail   = tail_q;
  assign upload_full = full;
  assign upload_busy = busy;
  assign err_len     = err_q;

endmodule

// File: tb/tb_ring_req_upload.sv
// Directed bench for ring_req_upload with 3-flit messages, two slots.
module tb_ring_req_upload;

  localparam int FW = 16;
  localparam int MF = 3;
  localparam int DP = 2;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW*MF-1:0] msg_flits;
  logic          v_msg_flits;
  logic [LW-1:0] msg_len;
  logic          req_fifo_rdy;
  logic [FW-1:0] flit_out;
  logic          v_flit_out;
  logic          flit_tail;
  logic          upload_full;
  logic          upload_busy;
  logic          err_len;

  int checks = 0;
  int fails  = 0;

  ring_req_upload #(
    .FLIT_W(FW), .MAX_FLITS(MF), .DEPTH(DP), .LEN_W(LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .msg_flits(msg_flits),
    .v_msg_flits(v_msg_flits),
    .msg_len(msg_len),
    .req_fifo_rdy(req_fifo_rdy),
    .flit_out(flit_out),
    .v_flit_out(v_flit_out),
    .flit_tail(flit_tail),
    .upload_full(upload_full),
    .upload_busy(upload_busy),
    .err_len(err_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_flit(input string tag, input logic [15:0] f,
                          input logic t);
    chk({tag, "_v"}, 64'(v_flit_out), 64'd1);
    chk({tag, "_f"}, 64'(flit_out), 64'(f));
    chk({tag, "_t"}, 64'(flit_tail), 64'(t));
  endtask

  task automatic load(input logic [47:0] m, input logic [1:0] l);
    msg_flits   = m;
    msg_len     = l;
    v_msg_flits = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    msg_flits = '0;
    v_msg_flits = 1'b0;
    msg_len = '0;
    req_fifo_rdy = 1'b0;
    tick();
    tick();
    chk("rst_f", 64'(flit_out), 64'd0);
    chk("rst_v", 64'(v_flit_out), 64'd0);
    chk("rst_t", 64'(flit_tail), 64'd0);
    chk("rst_full", 64'(upload_full), 64'd0);
    chk("rst_busy", 64'(upload_busy), 64'd0);
    chk("rst_err", 64'(err_len), 64'd0);
    #2 rst = 1'b1;

    // 1: basic three-flit message
    tick();
    load(48'h123456789abc, 2'd3);
    tick();
    v_msg_flits = 1'b0;
    chk("t1_v0", 64'(v_flit_out), 64'd0);
    chk("t1_busy", 64'(upload_busy), 64'd1);
    req_fifo_rdy = 1'b1;
    tick(); exp_flit("t1_a", 16'h1234, 1'b0);
    tick(); exp_flit("t1_b", 16'h5678, 1'b0);
    tick(); exp_flit("t1_c", 16'h9abc, 1'b1);
    chk("t1_idle", 64'(upload_busy), 64'd0);
    tick();
    chk("t1_nov", 64'(v_flit_out), 64'd0);
    req_fifo_rdy = 1'b0;

    // 2: grant toggling mid-message
    load(48'h2016c0de0330, 2'd3);
    tick();
    v_msg_flits = 1'b0;
    req_fifo_rdy = 1'b1;
    tick(); exp_flit("t2_a", 16'h2016, 1'b0);
    req_fifo_rdy = 1'b0;
    tick();
    chk("t2_bub_v", 64'(v_flit_out), 64'd0);
    chk("t2_bub_f", 64'(flit_out), 64'h2016);
    req_fifo_rdy = 1'b1;
    tick(); exp_flit("t2_b", 16'hc0de, 1'b0);
    tick(); exp_flit("t2_c", 16'h0330, 1'b1);
    req_fifo_rdy = 1'b0;

    // 3: fill both slots, extra load ignored
    load(48'hbeef00000000, 2'd1);
    tick();
    load(48'hcafe12340000, 2'd2);
    tick();
    chk("t3_full", 64'(upload_full), 64'd1);
    load(48'h111122223333, 2'd3);
    tick();
    v_msg_flits = 1'b0;
    chk("t3_full2", 64'(upload_full), 64'd1);
    chk("t3_noerr", 64'(err_len), 64'd0);
    req_fifo_rdy = 1'b1;
    tick(); exp_flit("t3_a", 16'hbeef, 1'b1);
    tick(); exp_flit("t3_b", 16'hcafe, 1'b0);
    tick(); exp_flit("t3_c", 16'h1234, 1'b1);
    chk("t3_idle", 64'(upload_busy), 64'd0);
    tick();
    chk("t3_no1111", 64'(v_flit_out), 64'd0);
    req_fifo_rdy = 1'b0;

    // 4: zero length rejected
    load(48'hdeaddeaddead, 2'd0);
    tick();
    v_msg_flits = 1'b0;
    chk("t4_err", 64'(err_len), 64'd1);
    chk("t4_busy", 64'(upload_busy), 64'd0);
    req_fifo_rdy = 1'b1;
    tick();
    chk("t4_err0", 64'(err_len), 64'd0);
    chk("t4_nov", 64'(v_flit_out), 64'd0);
    req_fifo_rdy = 1'b0;

    // 5: load racing the tail send at full, wrap-around order
    load(48'haaaa00000000, 2'd1);
    tick();
    load(48'hbbbbb2b20000, 2'd2);
    tick();
    chk("t5_full", 64'(upload_full), 64'd1);
    req_fifo_rdy = 1'b1;
    load(48'hcccc00000000, 2'd1);
    tick(); exp_flit("t5_a", 16'haaaa, 1'b1);
    chk("t5_nfull", 64'(upload_full), 64'd0);
    tick(); exp_flit("t5_b0", 16'hbbbb, 1'b0);
    chk("t5_cin", 64'(upload_full), 64'd1);
    load(48'hdddd00000000, 2'd1);
    tick(); exp_flit("t5_b1", 16'hb2b2, 1'b1);
    chk("t5_drej", 64'(upload_full), 64'd0);
    tick(); exp_flit("t5_c", 16'hcccc, 1'b1);
    chk("t5_cnt1", 64'(upload_busy), 64'd1);
    load(48'heeee00000000, 2'd1);
    tick(); exp_flit("t5_d", 16'hdddd, 1'b1);
    v_msg_flits = 1'b0;
    tick(); exp_flit("t5_e", 16'heeee, 1'b1);
    chk("t5_idle", 64'(upload_busy), 64'd0);
    tick();
    chk("t5_nov", 64'(v_flit_out), 64'd0);
    req_fifo_rdy = 1'b0;

    // 6: asynchronous reset mid-message
    load(48'h123456789abc, 2'd3);
    tick();
    v_msg_flits = 1'b0;
    req_fifo_rdy = 1'b1;
    tick(); exp_flit("t6_a", 16'h1234, 1'b0);
    tick(); exp_flit("t6_b", 16'h5678, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("t6_f", 64'(flit_out), 64'd0);
    chk("t6_v", 64'(v_flit_out), 64'd0);
    chk("t6_t", 64'(flit_tail), 64'd0);
    chk("t6_busy", 64'(upload_busy), 64'd0);
    chk("t6_full", 64'(upload_full), 64'd0);
    chk("t6_err", 64'(err_len), 64'd0);
    #2 rst = 1'b1;
    tick();
    chk("t6_nov0", 64'(v_flit_out), 64'd0);
    tick();
    chk("t6_nov1", 64'(v_flit_out), 64'd0);
    chk("t6_nbusy", 64'(upload_busy), 64'd0);
    load(48'h0f0f00000000, 2'd1);
    tick();
    v_msg_flits = 1'b0;
    tick(); exp_flit("t6_new", 16'h0f0f, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
